fold_psum_engine: RTL and testbench

FOLD_PSUM_ENGINE -- requirements
Module: fold_psum_engine

---
 rtl/fold_psum_engine_pkg.sv | 16 +
 rtl/fold_psum_engine_if.sv | 38 +++
 rtl/fold_psum_engine_lane_adder_tree.sv | 30 +++
 rtl/fold_psum_engine.sv | 151 +++++++++++++++
 tb/tb_fold_psum_engine.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fold_psum_engine_pkg.sv
// Shared constants and FSM encoding for the fold partial-sum engine.
package fold_psum_engine_pkg;

    localparam int PAR_CH  = 16;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int MAX_PIX = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fold_psum_engine_if.sv
// Fold control, product-beat stream and final-sum stream of the engine.
interface fold_psum_engine_if #(
    parameter int PAR_CH = fold_psum_engine_pkg::PAR_CH,
    parameter int DATA_W = fold_psum_engine_pkg::DATA_W,
    parameter int ACC_W  = fold_psum_engine_pkg::ACC_W
);

    logic                           fold_start;
    logic                           first_fold;
    logic                           last_fold;
    logic [15:0]                    ch_base;
    logic [15:0]                    Cin;
    logic [15:0]                    npix;

    logic                           in_valid;
    logic                           in_ready;
    logic [PAR_CH*DATA_W-1:0]       in_data;

    logic                           out_valid;
    logic                           out_ready;
    logic signed [ACC_W-1:0]        out_data;

    logic                           compute_done;
    logic                           busy;

    modport master (
        output fold_start, first_fold, last_fold, ch_base, Cin, npix,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, compute_done, busy
    );

    modport slave (
        input  fold_start, first_fold, last_fold, ch_base, Cin, npix,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, compute_done, busy
    );

endinterface

// File: rtl/fold_psum_engine_lane_adder_tree.sv
// Masks lanes beyond the channel count and sums the rest, sign-extended to ACC_W.
module lane_adder_tree #(
    parameter int PAR_CH = fold_psum_engine_pkg::PAR_CH,
    parameter int DATA_W = fold_psum_engine_pkg::DATA_W,
    parameter int ACC_W  = fold_psum_engine_pkg::ACC_W
) (
    input  logic [PAR_CH*DATA_W-1:0] lanes_i,
    input  logic [15:0]              ch_base_i,
    input  logic [15:0]              cin_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [DATA_W-1:0] lane;
    logic signed [ACC_W-1:0]  sum_acc;

    always_comb begin
        lane    = '0;
        sum_acc = '0;
        for (int k = 0; k < PAR_CH; k++) begin
            lane = lanes_i[k*DATA_W +: DATA_W];
            // 17-bit compare so ch_base near 0xFFFF cannot wrap past Cin
            if (({1'b0, ch_base_i} + 17'(k)) < {1'b0, cin_i}) begin
                sum_acc = sum_acc + {{(ACC_W-DATA_W){lane[DATA_W-1]}}, lane};
            end
        end
    end

    assign sum_o = sum_acc;

endmodule

// File: rtl/fold_psum_engine.sv
// Accumulates per-pixel partial sums over channel folds; the last fold streams final sums out.
module fold_psum_engine #(
    parameter int PAR_CH  = fold_psum_engine_pkg::PAR_CH,
    parameter int DATA_W  = fold_psum_engine_pkg::DATA_W,
    parameter int ACC_W   = fold_psum_engine_pkg::ACC_W,
    parameter int MAX_PIX = fold_psum_engine_pkg::MAX_PIX
) (
    input  logic                clk,
    input  logic                rst_n,
    fold_psum_engine_if.slave   bus
);

    import fold_psum_engine_pkg::*;

    localparam int PIX_W  = $clog2(MAX_PIX);
    localparam int NPIX_W = PIX_W + 1;

    state_e                  state_q, state_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic [NPIX_W-1:0]       npix_q, npix_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [15:0]             ch_base_q, ch_base_d;
    logic [15:0]             cin_q, cin_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;

    logic signed [ACC_W-1:0] psum_q [MAX_PIX];

    logic signed [ACC_W-1:0] lane_sum;
    logic signed [ACC_W-1:0] prev_sum;
    logic signed [ACC_W-1:0] new_sum;
    logic                    out_free;
    logic                    in_ready;
    logic                    beat;
    logic                    last_beat;

    lane_adder_tree #(
        .PAR_CH (PAR_CH),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_adder_tree (
        .lanes_i   (bus.in_data),
        .ch_base_i (ch_base_q),
        .cin_i     (cin_q),
        .sum_o     (lane_sum)
    );

    assign prev_sum  = first_q ? '0 : psum_q[pix_q];
    assign new_sum   = lane_sum + prev_sum;
    assign out_free  = !out_valid_q || bus.out_ready;
    // npix of zero never opens the input; non-final folds ignore the output slot
    assign in_ready  = (state_q == ACCUM) && (npix_q != '0) && (!last_q || out_free);
    assign beat      = in_ready && bus.in_valid;
    assign last_beat = beat && ({1'b0, pix_q} == (npix_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        npix_d      = npix_q;
        first_d     = first_q;
        last_d      = last_q;
        ch_base_d   = ch_base_q;
        cin_d       = cin_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (beat && last_q) begin
            out_valid_d = 1'b1;
            out_data_d  = new_sum;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.fold_start) begin
                    state_d   = ACCUM;
                    pix_d     = '0;
                    first_d   = bus.first_fold;
                    last_d    = bus.last_fold;
                    ch_base_d = bus.ch_base;
                    cin_d     = bus.Cin;
                    npix_d    = (bus.npix > 16'(MAX_PIX)) ? NPIX_W'(MAX_PIX)
                                                          : NPIX_W'(bus.npix);
                end
            end
            ACCUM: begin
                if (npix_q == '0) begin
                    state_d = FLUSH;
                end else if (beat) begin
                    pix_d = pix_q + 1'b1;
                    if (last_beat) begin
                        state_d = FLUSH;
                        pix_d   = '0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            npix_q      <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            ch_base_q   <= '0;
            cin_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            npix_q      <= npix_d;
            first_q     <= first_d;
            last_q      <= last_d;
            ch_base_q   <= ch_base_d;
            cin_q       <= cin_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Partial-sum store: no reset, contents only trusted after a first fold
    always_ff @(posedge clk) begin
        if (beat) begin
            psum_q[pix_q] <= new_sum;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.compute_done = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fold_psum_engine.sv
// Scoreboard bench for fold_psum_engine: model sums queued on each accepted beat, popped on output.
module tb_fold_psum_engine;

    localparam int PAR_CH  = 16;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int MAX_PIX = 64;

    logic clk;
    logic rst_n;

    fold_psum_engine_if #(.PAR_CH(PAR_CH), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    fold_psum_engine #(
        .PAR_CH (PAR_CH),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .MAX_PIX(MAX_PIX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int start_cyc = 0;
    bit rdy_rand = 1'b0;

    logic signed [ACC_W-1:0] exp_q [$];
    logic signed [ACC_W-1:0] exp_psum [MAX_PIX];

    bit cur_first, cur_last;
    int cur_chb, cur_cin;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lane_val(input int pat, input int p, input int k);
        case (pat)
            0:       return 1;
            1:       return -1;
            2:       return 2;
            4:       return -32768;
            default: return ((p * 37 + k * 11 + pat * 5) % 257) - 128;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.compute_done) done_cnt++;
            if (bus.in_valid && bus.in_ready) beat_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                check("out_avail", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic start_fold(input bit first, input bit last, input int chb, input int cinv, input int np);
        cur_first = first;
        cur_last  = last;
        cur_chb   = chb;
        cur_cin   = cinv;
        bus.fold_start = 1'b1;
        bus.first_fold = first;
        bus.last_fold  = last;
        bus.ch_base    = 16'(chb);
        bus.Cin        = 16'(cinv);
        bus.npix       = 16'(np);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.fold_start = 1'b0;
    endtask

    task automatic drive_beat(input int p, input int pat);
        logic [PAR_CH*DATA_W-1:0] d;
        logic signed [ACC_W-1:0]  nv;
        int s;
        bit ok;
        s = 0;
        for (int k = 0; k < PAR_CH; k++) begin
            d[k*DATA_W +: DATA_W] = DATA_W'(lane_val(pat, p, k));
            if (cur_chb + k < cur_cin) s += lane_val(pat, p, k);
        end
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("beat_accept", ok, 1'b1);
        if (ok) begin
            nv = cur_first ? ACC_W'(s) : exp_psum[p] + ACC_W'(s);
            exp_psum[p] = nv;
            if (cur_last) exp_q.push_back(nv);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int d0);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.compute_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 1'b1);
        @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("busy_clear", bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_fold(input bit first, input bit last, input int chb, input int cinv,
                            input int np, input int pat, input bit poke);
        int d0;
        int eff;
        d0  = done_cnt;
        eff = (np > MAX_PIX) ? MAX_PIX : np;
        start_fold(first, last, chb, cinv, np);
        for (int p = 0; p < eff; p++) begin
            drive_beat(p, pat);
            if (poke && p == 0) begin
                bus.in_valid   = 1'b0;
                bus.fold_start = 1'b1;
                bus.first_fold = 1'b1;
                bus.ch_base    = 16'd99;
                bus.npix       = 16'd0;
                @(posedge clk); #1;
                bus.fold_start = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        wait_done(d0);
    endtask

    task automatic stall_chk();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_vld_seen", ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("stall_in_ready", bus.in_ready, 1'b0);
            check("stall_vld_hold", bus.out_valid, 1'b1);
            if (exp_q.size() != 0) check("stall_data_hold", bus.out_data, exp_q[0]);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0;
        bit ok;
        rst_n          = 1'b0;
        bus.fold_start = 1'b0;
        bus.first_fold = 1'b0;
        bus.last_fold  = 1'b0;
        bus.ch_base    = '0;
        bus.Cin        = '0;
        bus.npix       = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_done", bus.compute_done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single fold, all lanes 1
        run_fold(1'b1, 1'b1, 0, 16, 4, 0, 1'b0);

        // three folds over Cin=40, stray fold_start during the middle fold
        run_fold(1'b1, 1'b0, 0,  40, 2, 0, 1'b0);
        run_fold(1'b0, 1'b0, 16, 40, 2, 0, 1'b1);
        run_fold(1'b0, 1'b1, 32, 40, 2, 0, 1'b0);

        // negative lanes
        run_fold(1'b1, 1'b1, 0, 16, 2, 1, 1'b0);

        // output backpressure on the last fold
        bus.out_ready = 1'b0;
        fork
            run_fold(1'b1, 1'b1, 0, 16, 3, 3, 1'b0);
            stall_chk();
        join
        bus.out_ready = 1'b1;

        // npix = 0
        d0 = done_cnt;
        b0 = beat_cnt;
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        start_fold(1'b1, 1'b1, 0, 16, 0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.compute_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("npix0_done", ok, 1'b1);
        check("npix0_latency", cyc - start_cyc, 3);
        check("npix0_beats", beat_cnt - b0, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("npix0_done_once", done_cnt - d0, 1);
        @(posedge clk); #1;

        // npix above MAX_PIX clamps
        run_fold(1'b1, 1'b1, 0, 16, 70, 3, 1'b0);

        // random output backpressure, masked lanes, large negative lanes
        rdy_rand = 1'b1;
        run_fold(1'b1, 1'b0, 0, 12, 6, 4, 1'b0);
        run_fold(1'b0, 1'b1, 0, 12, 6, 3, 1'b0);
        rdy_rand = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        // reset in the middle of a fold
        bus.out_ready = 1'b0;
        d0 = done_cnt;
        start_fold(1'b1, 1'b1, 0, 16, 8);
        drive_beat(0, 2);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_vld", bus.out_valid, 1'b1);
        check("pre_rst_data", bus.out_data, 32'sd32);
        check("pre_rst_busy", bus.busy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_data", bus.out_data, '0);
        check("mid_rst_done", bus.compute_done, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_busy", bus.busy, 1'b0);
        @(posedge clk); #1;

        // recovery after reset
        run_fold(1'b1, 1'b1, 0, 16, 2, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
